fb_sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO; successor to the first-generation fb FIFO.

---
 rtl/fb_sync_fifo.sv | 156 +++++++++++++++
 tb/tb_fb_sync_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fb_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define FB_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read.
module fb_sync_fifo #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 32,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] in,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          pop_ok, push_ok;
    logic [WIDTH-1:0] rd_data;

    // A pop frees a slot in the same cycle, so a full FIFO may accept a push alongside it.
    always_comb begin
        pop_ok  = pop & ~empty_q;
        push_ok = push & (~full_q | pop_ok);
        rd_data = mem[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);

        // Setting an error flag wins over a simultaneous clear.
        overflow_d = overflow_q;
        if (push & ~push_ok) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (pop & ~pop_ok) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

`ifdef FB_SYNC_FIFO_FWFT_EN
    // Head entry is presented directly; it is forced to zero while nothing is stored.
    assign out       = empty_q ? '0 : rd_data;
    assign out_valid = ~empty_q;
`else
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        out_d       = pop_ok ? rd_data : out_q;
        out_valid_d = pop_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fb_sync_fifo.sv
// Bench for fb_sync_fifo: a DEPTH=8 and a DEPTH=5 instance share one stimulus stream
// and are each compared every cycle against a queue-based reference model.
module tb_fb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] din = '0;

    logic [1:0][31:0] d_out;
    logic [1:0]       d_ovalid, d_full, d_empty, d_af, d_ae, d_ov, d_un;
    logic [3:0]       cnt_a;
    logic [2:0]       cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one queue per instance plus the visible output state.
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          dep [2] = '{8, 5};
    int          afl [2] = '{6, 4};
    int          ael [2] = '{2, 1};
    bit          mov [2];
    bit          mun [2];
    bit          mvalid [2];
    logic [31:0] mout [2];

    always #5 clk = ~clk;

    fb_sync_fifo #(.DEPTH(8), .WIDTH(32), .AF_LEVEL(6), .AE_LEVEL(2)) u_d8 (
        .clk(clk), .rst(rst), .push(push), .in(din), .pop(pop),
        .out(d_out[0]), .out_valid(d_ovalid[0]), .full(d_full[0]), .empty(d_empty[0]),
        .almost_full(d_af[0]), .almost_empty(d_ae[0]), .count(cnt_a),
        .overflow(d_ov[0]), .underflow(d_un[0]), .err_clr(err_clr)
    );

    fb_sync_fifo #(.DEPTH(5), .WIDTH(32), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
        .clk(clk), .rst(rst), .push(push), .in(din), .pop(pop),
        .out(d_out[1]), .out_valid(d_ovalid[1]), .full(d_full[1]), .empty(d_empty[1]),
        .almost_full(d_af[1]), .almost_empty(d_ae[1]), .count(cnt_b),
        .overflow(d_ov[1]), .underflow(d_un[1]), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s inst%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            mov[k]    = 1'b0;
            mun[k]    = 1'b0;
            mvalid[k] = 1'b0;
            mout[k]   = '0;
        end
    endtask

    task automatic model_update(input int k, input bit p, input bit r, input logic [31:0] d, input bit ec);
        logic [31:0] q [$];
        bit pop_ok, push_ok;
        if (k == 0) q = q0; else q = q1;
        pop_ok  = r && (q.size() > 0);
        push_ok = p && ((q.size() < dep[k]) || pop_ok);
        if (pop_ok) mout[k] = q.pop_front();
        if (push_ok) q.push_back(d);
        mvalid[k] = pop_ok;
        if (p && !push_ok) mov[k] = 1'b1;
        else if (ec) mov[k] = 1'b0;
        if (r && !pop_ok) mun[k] = 1'b1;
        else if (ec) mun[k] = 1'b0;
        if (k == 0) q0 = q; else q1 = q;
    endtask

    task automatic check_all();
        logic [31:0] q [$];
        int n;
        logic [31:0] cnt;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                q = q0;
                cnt = {28'd0, cnt_a};
            end else begin
                q = q1;
                cnt = {29'd0, cnt_b};
            end
            n = q.size();
            chk("count", k, cnt, n);
            chk("empty", k, {31'd0, d_empty[k]}, {31'd0, n == 0});
            chk("full", k, {31'd0, d_full[k]}, {31'd0, n == dep[k]});
            chk("almost_full", k, {31'd0, d_af[k]}, {31'd0, n >= afl[k]});
            chk("almost_empty", k, {31'd0, d_ae[k]}, {31'd0, n <= ael[k]});
            chk("overflow", k, {31'd0, d_ov[k]}, {31'd0, mov[k]});
            chk("underflow", k, {31'd0, d_un[k]}, {31'd0, mun[k]});
`ifdef FB_SYNC_FIFO_FWFT_EN
            chk("out_valid", k, {31'd0, d_ovalid[k]}, {31'd0, n != 0});
            if (n != 0) chk("out", k, d_out[k], q[0]);
`else
            chk("out_valid", k, {31'd0, d_ovalid[k]}, {31'd0, mvalid[k]});
            chk("out", k, d_out[k], mout[k]);
`endif
        end
    endtask

    task automatic step(input bit p, input bit r, input logic [31:0] d, input bit ec);
        push    = p;
        pop     = r;
        din     = d;
        err_clr = ec;
        @(posedge clk);
        model_update(0, p, r, d, ec);
        model_update(1, p, r, d, ec);
        @(negedge clk);
        cyc++;
        $display("cyc %0d push=%0b pop=%0b clr=%0b in=%h | d8 cnt=%0d out=%h v=%0b | d5 cnt=%0d out=%h v=%0b",
                 cyc, p, r, ec, d, cnt_a, d_out[0], d_ovalid[0], cnt_b, d_out[1], d_ovalid[1]);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // Fill past capacity: 9th push overflows the 8-deep instance.
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 32'hA5A5_0000 + 32'(i), 1'b0);
        // Drain plus one extra pop to provoke underflow.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Full FIFO with simultaneous push and pop, then drain.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h1000 + 32'(i), 1'b0);
        step(1'b1, 1'b1, 32'h0000_DEAD, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0, 1'b0);

        // Flag set takes priority over a same-cycle clear.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0, 1'b0);

        // Interleaved push/pop pairs exercise pointer wrap in both depths.
        for (int i = 0; i < 23; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b0);
            step(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'b0);
        end

        // Unconstrained random traffic including occasional error clears.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 $urandom, 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset with three entries stored.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h7000 + 32'(i), 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        step(1'b1, 1'b0, 32'h0000_BEEF, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
